rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 4096, instruction ROM capacity in 32-bit words.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(ROM_DEPTH), word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port byte_valid  input  1  source presents byte_data.
REQ-006 SHALL have port byte_data  input  8  stream byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts a byte; a transfer occurs on an edge with byte_valid && byte_ready.
REQ-008 SHALL have port rom_we  output  1  one-cycle ROM write strobe.
REQ-009 SHALL have port rom_waddr  output  ADDR_WIDTH  ROM word address.
REQ-010 SHALL have port rom_wdata  output  32  instruction word.
REQ-011 SHALL have port core_rst_n  output  1  active-low reset to riscv core.
REQ-012 SHALL have port load_done  output  1  image loaded.
REQ-013 SHALL have port load_err  output  1  load aborted.

Function
REQ-014 Stream format SHALL be: magic 0xA5, count low byte, count high byte, count x 4 data bytes (little-endian words), optional checksum (REQ-030).
REQ-015 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
REQ-016 IDLE/DONE/ERROR: transfer of 0xA5 -> LEN_LO, clears load_done and load_err, drives core_rst_n low next cycle; any other byte discarded, state held.
REQ-017 LEN_LO -> LEN_HI on next transfer; LEN_HI -> DATA on next transfer, latching 16-bit count.
REQ-018 Count 0 SHALL go straight to DONE (or CHECK with checksum 0x00 expected when enabled); no write.
REQ-019 Count > ROM_DEPTH SHALL go to ERROR on the LEN_HI transfer; no write.
REQ-020 DATA: byte k of a word SHALL land in rom_wdata bits [8k+7:8k].
REQ-021 rom_we SHALL pulse exactly one cycle, the cycle after the fourth byte's transfer, with rom_waddr = word index (first word 0, +1 per word) and rom_wdata stable that cycle.
REQ-022 After the final word's fourth byte, FSM SHALL go to CHECK (enabled) or DONE.
REQ-023 byte_ready SHALL be 1 in every state after reset; one byte per cycle sustained.
REQ-024 byte_valid low SHALL stall progress without state change; partial words are held.
REQ-025 load_done SHALL be 1 exactly while in DONE; load_err exactly while in ERROR.
REQ-026 core_rst_n SHALL be load_done registered one cycle later, so the core leaves reset only after the last rom_we completes.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, byte_ready=0, rom_we=0, rom_waddr=0, rom_wdata=0, core_rst_n=0, load_done=0, load_err=0, count and byte index 0.
REQ-028 Reset mid-load SHALL abandon the load; ROM contents already written are not reverted; core stays in reset until a full reload.
REQ-029 byte_ready SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-030 Macro ROM_LOADER_CHECKSUM_EN defined: CHECK state expects one byte = 8-bit sum mod 256 of all data bytes; match -> DONE, mismatch -> ERROR (words already written remain).
REQ-031 Macro undefined: no CHECK state, no checksum byte, DATA -> DONE directly.

Structure
REQ-032 Package rom_loader_pkg SHALL hold the state enum typedef, LOADER_MAGIC = 8'hA5 and instruction width 32.
REQ-033 Sub-module rom_loader_packer SHALL assemble bytes into words and produce the write strobe/address; FSM stays in rom_loader.

Verification
REQ-034 Stream A5 02 00 13 00 00 00 93 0D 50 00 -> rom_we at addr 0 data 0x00000013, addr 1 data 0x00500D93; load_done=1; core_rst_n=1 one cycle later.
REQ-035 Stream A5 01 00 followed by bytes with byte_valid toggling every other cycle -> single write only after fourth byte; no spurious rom_we.
REQ-036 ROM_DEPTH=16, stream A5 11 00 -> load_err=1, no rom_we, core_rst_n=0.
REQ-037 Checksum enabled, stream A5 01 00 01 02 03 04 0A -> DONE; same with last byte 0B -> ERROR, load_err=1, core_rst_n=0.
REQ-038 rst_n pulsed low after 6 data bytes of a 2-word load, then full reload -> all outputs reset values during reset, correct reload afterwards.
REQ-039 After DONE, second A5 01 00 EF BE AD DE -> core_rst_n drops, one write addr 0 data 0xDEADBEEF, core_rst_n rises again.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot ROM loader.
package rom_loader_pkg;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;
    localparam int         INSTR_WIDTH  = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/rom_loader_packer.sv
// Packs little-endian stream bytes into 32-bit ROM words and issues the write.
// Latency: rom_we one cycle after the fourth byte of a word; never stalls its source.
module rom_loader_packer
    import rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   byte_en,
    input  logic [7:0]             byte_data,
    output logic                   word_last,
    output logic [15:0]            word_idx,
    output logic                   rom_we,
    output logic [ADDR_WIDTH-1:0]  rom_waddr,
    output logic [INSTR_WIDTH-1:0] rom_wdata
);

    logic [1:0]  byte_idx;
    logic [23:0] word_buf;

    assign word_last = (byte_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= 2'd0;
            word_buf  <= 24'd0;
            word_idx  <= 16'd0;
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
        end else begin
            rom_we <= 1'b0;
            if (clear) begin
                byte_idx <= 2'd0;
                word_buf <= 24'd0;
                word_idx <= 16'd0;
            end else if (byte_en) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: word_buf[7:0]   <= byte_data;
                    2'd1: word_buf[15:8]  <= byte_data;
                    2'd2: word_buf[23:16] <= byte_data;
                    2'd3: begin
                        // rom_wdata only changes here, so it stays stable across the strobe
                        rom_wdata <= {byte_data, word_buf};
                        rom_waddr <= word_idx[ADDR_WIDTH-1:0];
                        rom_we    <= 1'b1;
                        word_idx  <= word_idx + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot loader: parses A5/count/data stream into ROM writes and holds the core in reset until loaded.
// Accepts one byte per cycle (byte_ready high after reset); ROM_LOADER_CHECKSUM_EN adds a trailing sum byte.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ROM_DEPTH  = 4096,
    parameter int ADDR_WIDTH = $clog2(ROM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   rom_we,
    output logic [ADDR_WIDTH-1:0]  rom_waddr,
    output logic [INSTR_WIDTH-1:0] rom_wdata,
    output logic                   core_rst_n,
    output logic                   load_done,
    output logic                   load_err
);

    localparam logic [16:0] DEPTH_LIM = 17'(ROM_DEPTH);

    loader_state_t state;
    logic [15:0]   count;
    logic [15:0]   new_count;
    logic [15:0]   word_idx;
    logic          word_last;
    logic          xfer;
    logic          start;
    logic          data_en;
    logic          final_byte;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    assign xfer       = byte_valid && byte_ready;
    assign start      = xfer && (byte_data == LOADER_MAGIC) &&
                        ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign data_en    = xfer && (state == DATA);
    assign new_count  = {byte_data, count[7:0]};
    assign final_byte = data_en && word_last && (word_idx == count - 16'd1);

    rom_loader_packer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start),
        .byte_en   (data_en),
        .byte_data (byte_data),
        .word_last (word_last),
        .word_idx  (word_idx),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= 16'd0;
            byte_ready <= 1'b0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum        <= 8'd0;
`endif
        end else begin
            byte_ready <= 1'b1;
            // Falls with load_done on a restart; rises one cycle after it so the last write has retired
            core_rst_n <= start ? 1'b0 : load_done;
            if (xfer) begin
                case (state)
                    IDLE, DONE, ERROR: begin
                        if (start) begin
                            state     <= LEN_LO;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
                            sum       <= 8'd0;
`endif
                        end
                    end
                    LEN_LO: begin
                        count <= {8'd0, byte_data};
                        state <= LEN_HI;
                    end
                    LEN_HI: begin
                        count <= new_count;
                        if (new_count == 16'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                            state     <= CHECK;
`else
                            state     <= DONE;
                            load_done <= 1'b1;
`endif
                        end else if ({1'b0, new_count} > DEPTH_LIM) begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        sum <= sum + byte_data;
                        if (final_byte) state <= CHECK;
`else
                        if (final_byte) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end
`endif
                    end
`ifdef ROM_LOADER_CHECKSUM_EN
                    CHECK: begin
                        if (byte_data == sum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader against a stream-level reference model.
module tb_rom_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst_n;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          rom_we;
    logic [AW-1:0] rom_waddr;
    logic [31:0]   rom_wdata;
    logic          core_rst_n;
    logic          load_done;
    logic          load_err;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] mon_addr[$];
    logic [31:0]   mon_data[$];
    logic [31:0]   words[DEPTH];

    rom_loader #(.ROM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .rom_we     (rom_we),
        .rom_waddr  (rom_waddr),
        .rom_wdata  (rom_wdata),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every cycle with rom_we high is one recorded write
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            mon_addr.push_back(rom_waddr);
            mon_data.push_back(rom_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        int n;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        do begin
            rdy = byte_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL byte_ready_timeout: byte_ready=%0b required 1", byte_ready);
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    // Stream-level model: header, optional garbage before it, words, optional checksum
    task automatic do_load(input int cnt, input int gmin, input int gmax,
                           input bit corrupt, input int ngarbage, input string name);
        logic [7:0]  sum;
        logic [15:0] c16;
        logic [7:0]  g;
        bit          exp_err;
        int          exp_writes;
        c16 = 16'(cnt);
        sum = 8'd0;
        mon_addr.delete();
        mon_data.delete();
        for (int i = 0; i < ngarbage; i++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h00;
            send_byte(g, $urandom_range(gmax, gmin));
        end
        send_byte(8'hA5, $urandom_range(gmax, gmin));
        send_byte(c16[7:0], $urandom_range(gmax, gmin));
        send_byte(c16[15:8], $urandom_range(gmax, gmin));
        checks++;
        if (core_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL %s core_rst_n_during_load: got %0b required 0", name, core_rst_n);
        end
        exp_err    = (cnt > DEPTH);
        exp_writes = exp_err ? 0 : cnt;
        if (!exp_err) begin
            for (int i = 0; i < cnt; i++) begin
                for (int k = 0; k < 4; k++) begin
                    sum = sum + words[i][8*k +: 8];
                    send_byte(words[i][8*k +: 8], $urandom_range(gmax, gmin));
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            send_byte(corrupt ? sum + 8'd1 : sum, $urandom_range(gmax, gmin));
            exp_err = corrupt;
`endif
        end
        @(negedge clk);
        checks++;
        if (load_done !== !exp_err || load_err !== exp_err || core_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL %s status: done=%0b err=%0b core_rst_n=%0b required done=%0b err=%0b core_rst_n=0",
                     name, load_done, load_err, core_rst_n, !exp_err, exp_err);
        end
        @(negedge clk);
        checks++;
        if (core_rst_n !== !exp_err) begin
            failures++;
            $display("FAIL %s core_rst_n_release: got %0b required %0b", name, core_rst_n, !exp_err);
        end
        checks++;
        if (mon_addr.size() != exp_writes) begin
            failures++;
            $display("FAIL %s write_count: got %0d required %0d", name, mon_addr.size(), exp_writes);
        end else begin
            for (int i = 0; i < exp_writes; i++) begin
                checks++;
                if (mon_addr[i] !== AW'(i) || mon_data[i] !== words[i]) begin
                    failures++;
                    $display("FAIL %s write[%0d]: addr=%0d data=%08h required addr=%0d data=%08h",
                             name, i, mon_addr[i], mon_data[i], i, words[i]);
                end
            end
        end
    endtask

    task automatic fill_words();
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({byte_ready, rom_we, rom_waddr, rom_wdata, core_rst_n, load_done, load_err} !== '0) begin
            failures++;
            $display("FAIL %s outputs_in_reset: ready=%0b we=%0b addr=%0d data=%08h core_rst_n=%0b done=%0b err=%0b required all 0",
                     name, byte_ready, rom_we, rom_waddr, rom_wdata, core_rst_n, load_done, load_err);
        end
    endtask

    task automatic test_reset();
        #3;
        check_all_zero("reset_async");
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        #1;
        checks++;
        if (byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_before_edge: got %0b required 0", byte_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (byte_ready !== 1'b1 || core_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_rise: ready=%0b core_rst_n=%0b required ready=1 core_rst_n=0",
                     byte_ready, core_rst_n);
        end
    endtask

    task automatic test_basic();
        words[0] = 32'h0000_0013;
        words[1] = 32'h0050_0D93;
        do_load(2, 0, 0, 1'b0, 0, "basic");
    endtask

    task automatic test_stall();
        fill_words();
        do_load(1, 1, 1, 1'b0, 0, "stall_toggle");
        fill_words();
        do_load(3, 0, 3, 1'b0, 0, "stall_random");
    endtask

    task automatic test_bounds();
        do_load(17, 0, 0, 1'b0, 0, "overflow");
        fill_words();
        do_load(16, 0, 0, 1'b0, 0, "full_depth");
        do_load(0, 0, 0, 1'b0, 0, "count_zero");
    endtask

`ifdef ROM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        words[0] = 32'h0403_0201;
        do_load(1, 0, 0, 1'b0, 0, "checksum_good");
        do_load(1, 0, 0, 1'b1, 0, "checksum_bad");
    endtask
`endif

    task automatic test_midload_reset();
        fill_words();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(words[i / 4][8*(i % 4) +: 8], 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midload_reset_async");
        @(negedge clk);
        check_all_zero("midload_reset_held");
        rst_n = 1'b1;
        fill_words();
        do_load(2, 0, 1, 1'b0, 0, "midload_reload");
    endtask

    task automatic test_reload();
        words[0] = 32'hDEAD_BEEF;
        do_load(1, 0, 0, 1'b0, 0, "reload");
    endtask

    task automatic test_random();
        bit corrupt;
        for (int it = 0; it < 8; it++) begin
            fill_words();
            corrupt = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            corrupt = 1'($urandom_range(1, 0));
`endif
            do_load($urandom_range(17, 0), 0, 2, corrupt, $urandom_range(3, 0), "random");
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_bounds();
`ifdef ROM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_midload_reset();
        test_basic();
        test_reload();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
